// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect,
// mid-bit sampling of start/data/stop, one-cycle valid and frame-error pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       RxSerial,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       FrameError,
  output logic       Busy
);

  localparam int unsigned TIMER_W = 13;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DATA_W  = 8;

  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_prev;
  logic [1:0]         r_fill;
  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic               r_ferr;
  logic               r_busy;

  state_t             w_state_next;
  logic [TIMER_W-1:0] w_timer_next;
  logic [IDX_W-1:0]   w_idx_next;
  logic [DATA_W-1:0]  w_shift_next;
  logic [DATA_W-1:0]  w_data_next;
  logic               w_valid_next;
  logic               w_ferr_next;
  logic               w_rx;
  logic               w_fall;

  // r_fill marks when r_sync2 carries a real line sample rather than its reset
  // value, so a line that is low out of reset never looks like a 1->0 edge.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_sync1 <= RxSerial;
      r_sync2 <= r_sync1;
      r_prev  <= r_fill[1] ? r_sync2 : 1'b0;
      r_fill  <= {r_fill[0], 1'b1};
    end
  end

  assign w_rx   = r_sync2;
  assign w_fall = r_fill[1] & r_prev & ~w_rx;

  // State and datapath registers
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_ferr  <= w_ferr_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer_next = '0;
        w_idx_next   = '0;
        if (w_fall) begin
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (r_timer == HALF_LAST) begin
          w_timer_next = '0;
          w_idx_next   = '0;
          w_state_next = w_rx ? S_IDLE : S_DATA;
        end else begin
          w_timer_next = r_timer + TIMER_W'(1);
        end
      end

      S_DATA: begin
        if (r_timer == BIT_LAST) begin
          w_shift_next[r_idx] = w_rx;
          w_timer_next        = '0;
          w_idx_next          = r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) begin
            w_state_next = S_STOP;
          end
        end else begin
          w_timer_next = r_timer + TIMER_W'(1);
        end
      end

      S_STOP: begin
        if (r_timer == BIT_LAST) begin
          w_timer_next = '0;
          w_state_next = S_IDLE;
          if (w_rx) begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
          end else begin
            w_ferr_next  = 1'b1;
          end
        end else begin
          w_timer_next = r_timer + TIMER_W'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_timer_next = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  assign RxData     = r_data;
  assign RxValid    = r_valid;
  assign FrameError = r_ferr;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a byte-level model of the 8N1 receiver,
// with latency, busy-time, glitch, framing-error and reset-abort scenarios.
module tb_uart_rx;

  localparam int unsigned N      = 16;
  localparam int          BIT_NS = 160;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .CLK        (clk),
    .Reset_n    (rst_n),
    .RxSerial   (rx),
    .RxData     (rx_data),
    .RxValid    (rx_valid),
    .FrameError (frame_err),
    .Busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc       = 0;
  int n_valid   = 0;
  int n_fe      = 0;
  int n_both    = 0;
  int busy_cnt  = 0;
  int valid_cyc = 0;
  logic [7:0] got [64];

  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) cyc++;

  // Observe outputs away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      if (n_valid < 64) got[n_valid] = rx_data;
      valid_cyc = cyc;
      n_valid++;
    end
    if (frame_err) n_fe++;
    if (rx_valid && frame_err) n_both++;
    if (busy) busy_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Drive the first nbits bits of a frame (10 = whole frame), leaving rx at the last bit
  task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)      rx = 1'b0;
      else if (i < 9)  rx = b[i-1];
      else             rx = stop;
      #(bit_ns);
    end
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  int v0, f0, b0, t0;
  logic [7:0] model_data;
  logic [7:0] exp_q [$];
  int         exp_fe;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    #23;
    check("reset_rxdata", 32'(rx_data), 32'h00);
    check("reset_valid",  32'(rx_valid), 32'h0);
    check("reset_ferr",   32'(frame_err), 32'h0);
    check("reset_busy",   32'(busy), 32'h0);
    sync_edge();
    rst_n = 1'b1;
    repeat (4) sync_edge();
    model_data = 8'h00;

    // Single frame 0xA5 with idle before and after
    sync_edge();
    v0 = n_valid; f0 = n_fe; b0 = busy_cnt; t0 = cyc;
    send_frame(8'hA5, BIT_NS, 1'b1, 10);
    rx = 1'b1;
    #(2 * BIT_NS);
    model_data = 8'hA5;
    check("a5_pulses", 32'(n_valid - v0), 32'd1);
    check("a5_got", 32'(got[v0]), 32'(model_data));
    check("a5_rxdata", 32'(rx_data), 32'(model_data));
    check("a5_ferr", 32'(n_fe - f0), 32'd0);
    check_range("a5_busy_cycles", busy_cnt - b0, 148, 156);
    // Two synchronizer cycles plus N/2 + 9N, +/-1
    check_range("a5_latency", valid_cyc - t0, 2 + N/2 + 9*N - 1, 2 + N/2 + 9*N + 1);

    // 0x00 then 0xFF with a one-bit idle gap
    sync_edge();
    v0 = n_valid; f0 = n_fe;
    send_frame(8'h00, BIT_NS, 1'b1, 10);
    rx = 1'b1;
    #(BIT_NS);
    send_frame(8'hFF, BIT_NS, 1'b1, 10);
    rx = 1'b1;
    #(2 * BIT_NS);
    model_data = 8'hFF;
    check("b2b_pulses", 32'(n_valid - v0), 32'd2);
    check("b2b_first", 32'(got[v0]), 32'h00);
    check("b2b_second", 32'(got[v0+1]), 32'hFF);
    check("b2b_ferr", 32'(n_fe - f0), 32'd0);

    // Short low glitch is rejected at the start-bit mid sample
    sync_edge();
    v0 = n_valid; f0 = n_fe;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("glitch_busy_low", 32'(busy), 32'h0);
    #(2 * BIT_NS);
    check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    check("glitch_no_ferr", 32'(n_fe - f0), 32'd0);

    // Stop bit low, line held low 3 bit times afterwards
    sync_edge();
    v0 = n_valid; f0 = n_fe;
    send_frame(8'h3C, BIT_NS, 1'b0, 10);
    #(3 * BIT_NS);
    check("fe_pulses", 32'(n_fe - f0), 32'd1);
    check("fe_no_valid", 32'(n_valid - v0), 32'd0);
    check("fe_rxdata_held", 32'(rx_data), 32'(model_data));
    check("fe_no_restart", 32'(busy), 32'h0);
    rx = 1'b1;
    #(2 * BIT_NS);

    // Reset mid-DATA of 0x55, release with the line low, then receive 0x81
    sync_edge();
    v0 = n_valid; f0 = n_fe;
    send_frame(8'h55, BIT_NS, 1'b1, 5);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy), 32'h0);
    check("rst_async_rxdata", 32'(rx_data), 32'h00);
    model_data = 8'h00;
    rx = 1'b0;
    #50;
    sync_edge();
    rst_n = 1'b1;
    b0 = busy_cnt;
    #(3 * BIT_NS);
    check("rst_low_line_no_start", 32'(busy_cnt - b0), 32'd0);
    check("rst_abort_no_pulse", 32'(n_valid - v0 + n_fe - f0), 32'd0);
    rx = 1'b1;
    #(2 * BIT_NS);
    sync_edge();
    v0 = n_valid; f0 = n_fe;
    send_frame(8'h81, BIT_NS, 1'b1, 10);
    rx = 1'b1;
    #(2 * BIT_NS);
    model_data = 8'h81;
    check("post_rst_pulses", 32'(n_valid - v0), 32'd1);
    check("post_rst_data", 32'(rx_data), 32'(model_data));
    check("post_rst_ferr", 32'(n_fe - f0), 32'd0);

    // Sender at -3% and +3% bit time
    for (int k = 0; k < 2; k++) begin
      sync_edge();
      v0 = n_valid; f0 = n_fe;
      send_frame(8'h6E, (k == 0) ? 155 : 165, 1'b1, 10);
      rx = 1'b1;
      #(2 * BIT_NS);
      model_data = 8'h6E;
      check($sformatf("skew%0d_pulses", k), 32'(n_valid - v0), 32'd1);
      check($sformatf("skew%0d_data", k), 32'(rx_data), 32'(model_data));
      check($sformatf("skew%0d_ferr", k), 32'(n_fe - f0), 32'd0);
    end

    // Random bytes, random skew, occasional bad stop bit
    sync_edge();
    v0 = n_valid; f0 = n_fe;
    exp_fe = 0;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      logic       stop;
      int         bt;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      bt   = $urandom_range(155, 165);
      send_frame(b, bt, stop, 10);
      rx = 1'b1;
      #($urandom_range(1, 3) * BIT_NS);
      if (stop) begin
        exp_q.push_back(b);
        model_data = b;
      end else begin
        exp_fe++;
      end
    end
    #(BIT_NS);
    check("rand_pulses", 32'(n_valid - v0), 32'(exp_q.size()));
    check("rand_ferr", 32'(n_fe - f0), 32'(exp_fe));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand_byte%0d", i), 32'(got[v0+i]), 32'(exp_q[i]));
    end
    check("rand_final_rxdata", 32'(rx_data), 32'(model_data));

    check("valid_ferr_exclusive", 32'(n_both), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
